// File: rtl/icebus_status_frame_receiver.sv
// Status-frame receive stage: hunts for the response header, collects one fixed-length
// frame, checks CRC16 and responder id, and presents the decoded motor telemetry.
module icebus_status_frame_receiver #(
  parameter logic [31:0] HEADER              = 32'h1CEB00DA,
  parameter int unsigned BYTE_TIMEOUT_CYCLES = 5000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               abort,
  input  logic [7:0]         expected_id,
  output logic               frame_valid,
  output logic [7:0]         id,
  output logic signed [23:0] encoder0_position,
  output logic signed [23:0] encoder1_position,
  output logic signed [15:0] current,
  output logic signed [23:0] duty,
  output logic signed [23:0] displacement,
  output logic               crc_error,
  output logic               id_mismatch,
  output logic               byte_timeout,
  output logic [31:0]        frames_ok,
  output logic [31:0]        frames_bad,
  output logic               busy
);

  localparam int unsigned GapW       = $clog2(BYTE_TIMEOUT_CYCLES + 1);
  localparam int unsigned PayloadLen = 15;
  localparam int unsigned FrameLen   = 17;

  typedef enum logic [1:0] {StHunt, StReceive, StCheck} state_e;

  state_e               state_q, state_d;
  logic [31:0]          hdr_q, hdr_d;
  logic [31:0]          hdr_shift;
  logic [4:0]           byte_cnt_q, byte_cnt_d;
  logic [15:0]          crc_q, crc_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic [8*FrameLen-1:0] buf_q, buf_d;

  logic [7:0]           id_q, id_d;
  logic [23:0]          enc0_q, enc0_d;
  logic [23:0]          enc1_q, enc1_d;
  logic [15:0]          cur_q, cur_d;
  logic [23:0]          duty_q, duty_d;
  logic [23:0]          disp_q, disp_d;

  logic                 valid_q, valid_d;
  logic                 crc_err_q, crc_err_d;
  logic                 mismatch_q, mismatch_d;
  logic                 timeout_q, timeout_d;
  logic [31:0]          ok_cnt_q, ok_cnt_d;
  logic [31:0]          bad_cnt_q, bad_cnt_d;
  logic                 ok_inc, bad_inc;

  // Frame buffer layout after the last byte: id, enc0, enc1, current, duty, disp, crc.
  logic [7:0]           f_id;
  logic [23:0]          f_enc0, f_enc1, f_duty, f_disp;
  logic [15:0]          f_cur, f_crc;

  assign f_id   = buf_q[135:128];
  assign f_enc0 = buf_q[127:104];
  assign f_enc1 = buf_q[103:80];
  assign f_cur  = buf_q[79:64];
  assign f_duty = buf_q[63:40];
  assign f_disp = buf_q[39:16];
  assign f_crc  = buf_q[15:0];

  assign hdr_shift = {hdr_q[23:0], rx_data};

  // CRC16 poly 0x8005, MSB-first: data bit 7 enters the register first.
  function automatic logic [15:0] crc16_update(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ 16'h8005;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    gap_d      = gap_q;
    buf_d      = buf_q;
    id_d       = id_q;
    enc0_d     = enc0_q;
    enc1_d     = enc1_q;
    cur_d      = cur_q;
    duty_d     = duty_q;
    disp_d     = disp_q;
    valid_d    = 1'b0;
    crc_err_d  = 1'b0;
    mismatch_d = 1'b0;
    timeout_d  = 1'b0;
    ok_inc     = 1'b0;
    bad_inc    = 1'b0;

    case (state_q)
      StHunt: begin
        if (abort) begin
          hdr_d = '0;
        end else if (rx_valid) begin
          hdr_d = hdr_shift;
          if (hdr_shift == HEADER) begin
            // Clearing here means HUNT is always re-entered with an empty register.
            state_d    = StReceive;
            hdr_d      = '0;
            byte_cnt_d = '0;
            crc_d      = 16'hFFFF;
            gap_d      = '0;
          end
        end
      end

      StReceive: begin
        if (abort) begin
          state_d = StHunt;
        end else if (rx_valid) begin
          buf_d      = {buf_q[8*FrameLen-9:0], rx_data};
          byte_cnt_d = byte_cnt_q + 5'd1;
          gap_d      = '0;
          if (byte_cnt_q < 5'(PayloadLen)) begin
            crc_d = crc16_update(crc_q, rx_data);
          end
          if (byte_cnt_q == 5'(FrameLen - 1)) begin
            state_d = StCheck;
          end
        end else if (gap_q == GapW'(BYTE_TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          bad_inc   = 1'b1;
          state_d   = StHunt;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      StCheck: begin
        state_d = StHunt;
        if (!abort) begin
          if (crc_q != f_crc) begin
            crc_err_d = 1'b1;
            bad_inc   = 1'b1;
          end else if ((f_id == expected_id) || (expected_id == 8'hFF)) begin
            id_d    = f_id;
            enc0_d  = f_enc0;
            enc1_d  = f_enc1;
            cur_d   = f_cur;
            duty_d  = f_duty;
            disp_d  = f_disp;
            valid_d = 1'b1;
            ok_inc  = 1'b1;
          end else begin
            mismatch_d = 1'b1;
            bad_inc    = 1'b1;
          end
        end
      end

      default: state_d = StHunt;
    endcase

    ok_cnt_d  = (ok_inc && (ok_cnt_q != '1)) ? ok_cnt_q + 32'd1 : ok_cnt_q;
    bad_cnt_d = (bad_inc && (bad_cnt_q != '1)) ? bad_cnt_q + 32'd1 : bad_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StHunt;
      hdr_q      <= '0;
      byte_cnt_q <= '0;
      crc_q      <= '0;
      gap_q      <= '0;
      buf_q      <= '0;
      id_q       <= '0;
      enc0_q     <= '0;
      enc1_q     <= '0;
      cur_q      <= '0;
      duty_q     <= '0;
      disp_q     <= '0;
      valid_q    <= 1'b0;
      crc_err_q  <= 1'b0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
      ok_cnt_q   <= '0;
      bad_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      gap_q      <= gap_d;
      buf_q      <= buf_d;
      id_q       <= id_d;
      enc0_q     <= enc0_d;
      enc1_q     <= enc1_d;
      cur_q      <= cur_d;
      duty_q     <= duty_d;
      disp_q     <= disp_d;
      valid_q    <= valid_d;
      crc_err_q  <= crc_err_d;
      mismatch_q <= mismatch_d;
      timeout_q  <= timeout_d;
      ok_cnt_q   <= ok_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign frame_valid       = valid_q;
  assign crc_error         = crc_err_q;
  assign id_mismatch       = mismatch_q;
  assign byte_timeout      = timeout_q;
  assign id                = id_q;
  assign encoder0_position = enc0_q;
  assign encoder1_position = enc1_q;
  assign current           = cur_q;
  assign duty              = duty_q;
  assign displacement      = disp_q;
  assign frames_ok         = ok_cnt_q;
  assign frames_bad        = bad_cnt_q;
  assign busy              = (state_q != StHunt);

endmodule

// File: tb/tb_icebus_status_frame_receiver.sv
// Directed bench for icebus_status_frame_receiver: table of frames plus hand-written
// sequences for partial headers, byte timeout, abort and mid-frame reset.
module tb_icebus_status_frame_receiver;

  localparam logic [31:0] Hdr     = 32'h1CEB00DA;
  localparam int          Timeout = 5000;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               rx_valid = 1'b0;
  logic [7:0]         rx_data = 8'h00;
  logic               abort = 1'b0;
  logic [7:0]         expected_id = 8'h00;
  logic               frame_valid;
  logic [7:0]         id;
  logic signed [23:0] encoder0_position;
  logic signed [23:0] encoder1_position;
  logic signed [15:0] current;
  logic signed [23:0] duty;
  logic signed [23:0] displacement;
  logic               crc_error;
  logic               id_mismatch;
  logic               byte_timeout;
  logic [31:0]        frames_ok;
  logic [31:0]        frames_bad;
  logic               busy;

  icebus_status_frame_receiver #(
    .HEADER              (Hdr),
    .BYTE_TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .rx_valid          (rx_valid),
    .rx_data           (rx_data),
    .abort             (abort),
    .expected_id       (expected_id),
    .frame_valid       (frame_valid),
    .id                (id),
    .encoder0_position (encoder0_position),
    .encoder1_position (encoder1_position),
    .current           (current),
    .duty              (duty),
    .displacement      (displacement),
    .crc_error         (crc_error),
    .id_mismatch       (id_mismatch),
    .byte_timeout      (byte_timeout),
    .frames_ok         (frames_ok),
    .frames_bad        (frames_bad),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int fv_count = 0;

  // Model of the last good frame and the health counters.
  logic [7:0]  m_id;
  logic [23:0] m_e0, m_e1, m_duty, m_disp;
  logic [15:0] m_cur;
  logic [31:0] m_ok, m_bad;

  typedef struct {
    logic [7:0]  fid;
    logic [23:0] e0;
    logic [23:0] e1;
    logic [15:0] cur;
    logic [23:0] dty;
    logic [23:0] dsp;
    logic [7:0]  exp_id;
    logic [7:0]  crc_flip;
    int          kind;  // 0 good, 1 crc error, 2 id mismatch
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // At most one strobe per cycle; also tallies good-frame strobes.
  always @(negedge clk) begin
    if (reset) begin
      if (int'(frame_valid) + int'(crc_error) + int'(id_mismatch) + int'(byte_timeout) > 1) begin
        mismatched++;
        $display("FAIL strobe_exclusive: got %b%b%b%b expected at most one high",
                 frame_valid, crc_error, id_mismatch, byte_timeout);
      end
      if (frame_valid) fv_count++;
    end
  end

  function automatic logic [15:0] model_crc(input logic [119:0] p);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < 15; k++) begin
      c = c ^ {p[119-8*k -: 8], 8'h00};
      for (int b = 0; b < 8; b++) begin
        c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
      end
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_header();
    for (int k = 0; k < 4; k++) send_byte(Hdr[31-8*k -: 8]);
  endtask

  task automatic send_payload(input logic [119:0] p, input int n);
    for (int k = 0; k < n; k++) send_byte(p[119-8*k -: 8]);
  endtask

  task automatic send_frame(input logic [119:0] p, input logic [7:0] flip);
    logic [15:0] c;
    c = model_crc(p);
    send_header();
    send_payload(p, 15);
    send_byte(c[15:8]);
    send_byte(c[7:0] ^ flip);
  endtask

  task automatic check_fields(input string tag);
    check({tag, "_id"},   {24'd0, id},                {24'd0, m_id});
    check({tag, "_enc0"}, {8'd0, encoder0_position},  {8'd0, m_e0});
    check({tag, "_enc1"}, {8'd0, encoder1_position},  {8'd0, m_e1});
    check({tag, "_cur"},  {16'd0, current},           {16'd0, m_cur});
    check({tag, "_duty"}, {8'd0, duty},               {8'd0, m_duty});
    check({tag, "_disp"}, {8'd0, displacement},       {8'd0, m_disp});
    check({tag, "_ok"},   frames_ok,                  m_ok);
    check({tag, "_bad"},  frames_bad,                 m_bad);
  endtask

  // Called on the negedge right after the last crc byte was sampled.
  task automatic expect_result(input string tag, input int kind, input logic [119:0] p);
    logic [3:0] exp;
    check({tag, "_early"}, {28'd0, frame_valid, crc_error, id_mismatch, byte_timeout}, 32'd0);
    @(negedge clk);
    exp = 4'b0000;
    case (kind)
      0: begin
        exp = 4'b1000;
        m_ok++;
        {m_id, m_e0, m_e1, m_cur, m_duty, m_disp} = p;
      end
      1: begin exp = 4'b0100; m_bad++; end
      default: begin exp = 4'b0010; m_bad++; end
    endcase
    check({tag, "_strobe"}, {28'd0, frame_valid, crc_error, id_mismatch, byte_timeout},
          {28'd0, exp});
    check_fields(tag);
    @(negedge clk);
    check({tag, "_pulse"}, {28'd0, frame_valid, crc_error, id_mismatch, byte_timeout}, 32'd0);
  endtask

  initial begin
    logic [119:0] p;
    logic [119:0] good;
    int fv_before;
    int waited;

    vecs[0] = '{8'h03, 24'h000102, 24'hFFFFFE, 16'h8001, 24'h001000, 24'h7FFFFF, 8'h03, 8'h00, 0};
    vecs[1] = '{8'h03, 24'h000102, 24'hFFFFFE, 16'h8001, 24'h001000, 24'h7FFFFF, 8'h03, 8'h01, 1};
    vecs[2] = '{8'h05, 24'h123456, 24'h800000, 16'h7FFF, 24'hABCDEF, 24'h000001, 8'h03, 8'h00, 2};
    vecs[3] = '{8'h05, 24'h123456, 24'h800000, 16'h7FFF, 24'hABCDEF, 24'h000001, 8'hFF, 8'h00, 0};
    good = {8'h07, 24'h00AA55, 24'hFF0000, 16'h0123, 24'h00FF00, 24'hFEDCBA};

    {m_id, m_e0, m_e1, m_cur, m_duty, m_disp} = '0;
    m_ok = 0;
    m_bad = 0;

    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check_fields("reset");
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      expected_id = vecs[v].exp_id;
      p = {vecs[v].fid, vecs[v].e0, vecs[v].e1, vecs[v].cur, vecs[v].dty, vecs[v].dsp};
      send_frame(p, vecs[v].crc_flip);
      expect_result($sformatf("vec%0d", v), vecs[v].kind, p);
      if (v == 0) begin
        check("enc1_signed", 32'(encoder1_position), 32'hFFFFFFFE);
        check("cur_signed",  32'(current),           32'hFFFF8001);
      end
    end

    // Partial headers only, then a real frame: exactly one good frame.
    expected_id = 8'hFF;
    fv_before = fv_count;
    send_byte(8'h1C); send_byte(8'hEB); send_byte(8'h1C); send_byte(8'hEB);
    send_byte(8'h00); send_byte(8'hDB); send_byte(8'h1C); send_byte(8'hEB);
    send_byte(8'h00);
    check("garbage_idle", {31'd0, busy}, 32'd0);
    send_frame(good, 8'h00);
    expect_result("garbage", 0, good);
    repeat (3) @(negedge clk);
    check("garbage_one_valid", 32'(fv_count - fv_before), 32'd1);

    // Byte timeout after 10 payload bytes.
    send_header();
    send_payload(good, 10);
    waited = 0;
    while (!byte_timeout && waited < Timeout + 100) begin
      @(negedge clk);
      waited++;
    end
    m_bad++;
    check("timeout_cycles", 32'(waited), 32'(Timeout));
    check("timeout_busy", {31'd0, busy}, 32'd0);
    check("timeout_bad", frames_bad, m_bad);
    @(negedge clk);
    send_frame(vecs[0].fid == 8'h03 ? good : good, 8'h00);
    expect_result("post_timeout", 0, good);

    // Abort together with the 8th payload byte.
    p = {vecs[0].fid, vecs[0].e0, vecs[0].e1, vecs[0].cur, vecs[0].dty, vecs[0].dsp};
    send_header();
    send_payload(p, 7);
    abort = 1'b1;
    send_byte(p[119-8*7 -: 8]);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    fv_before = fv_count;
    repeat (5) @(negedge clk);
    check("abort_no_strobe", {28'd0, frame_valid, crc_error, id_mismatch, byte_timeout}, 32'd0);
    check("abort_no_valid", 32'(fv_count - fv_before), 32'd0);
    check_fields("abort");

    // Reset mid-frame, then the tail of that frame must not lock.
    send_header();
    send_payload(p, 5);
    reset = 1'b0;
    #1;
    {m_id, m_e0, m_e1, m_cur, m_duty, m_disp} = '0;
    m_ok = 0;
    m_bad = 0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_strobes", {28'd0, frame_valid, crc_error, id_mismatch, byte_timeout}, 32'd0);
    check_fields("rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    fv_before = fv_count;
    for (int k = 5; k < 15; k++) send_byte(p[119-8*k -: 8]);
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (3) @(negedge clk);
    check("rst_tail_busy", {31'd0, busy}, 32'd0);
    check("rst_tail_no_valid", 32'(fv_count - fv_before), 32'd0);
    send_frame(good, 8'h00);
    expect_result("post_reset", 0, good);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
